// File: rtl/wb_cdb_arbiter.sv
// wb_cdb_arbiter: round-robin share of the CDB among ALU, LSU and BRU completions.
// Optional conflict counters enabled by defining WB_ARB_PERF_EN.
module wb_cdb_arbiter #(
  parameter int XLEN   = 32,
  parameter int ROB_W  = 5,
  parameter int PREG_W = 6,
  parameter int WB_W   = 1 + ROB_W + PREG_W + XLEN + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic [WB_W-1:0] alu_pkt_i,
  output logic            alu_ready_o,
  input  logic [WB_W-1:0] lsu_pkt_i,
  output logic            lsu_ready_o,
  input  logic [WB_W-1:0] bru_pkt_i,
  output logic            bru_ready_o,
  output logic [WB_W-1:0] cdb_pkt_o,
  output logic [2:0]      grant_o,
  output logic [95:0]     perf_conflict_o
);

  localparam int NSRC = 3;
  localparam int VBIT = 1 + XLEN + PREG_W + ROB_W;

  logic [WB_W-1:0] pkt_in [NSRC];
  logic [WB_W-1:0] buf_q  [NSRC];
  logic [WB_W-1:0] buf_d  [NSRC];

  logic [NSRC-1:0] buf_v;
  logic [NSRC-1:0] gnt;
  logic [NSRC-1:0] rdy;
  logic [NSRC-1:0] acc;

  logic [1:0] rr_ptr_q, rr_ptr_d;
  logic [1:0] ord0, ord1, ord2;
  logic [1:0] gnt_idx;
  logic       gnt_any;

  logic [WB_W-1:0] cdb_q, cdb_d;
  logic [2:0]      grant_q, grant_d;
  logic [WB_W-1:0] gnt_pkt;

  function automatic logic [1:0] nxt(input logic [1:0] p);
    return (p >= 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign pkt_in[0] = alu_pkt_i;
  assign pkt_in[1] = lsu_pkt_i;
  assign pkt_in[2] = bru_pkt_i;

  // Buffer occupancy taken from each entry's valid bit.
  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      buf_v[i] = buf_q[i][VBIT];
    end
  end

  // Rotating priority search starting at rr_ptr.
  always_comb begin
    ord0    = (rr_ptr_q > 2'd2) ? 2'd0 : rr_ptr_q;
    ord1    = nxt(ord0);
    ord2    = nxt(ord1);
    gnt_idx = 2'd0;
    gnt_any = 1'b0;
    if (buf_v[ord0]) begin
      gnt_idx = ord0;
      gnt_any = 1'b1;
    end else if (buf_v[ord1]) begin
      gnt_idx = ord1;
      gnt_any = 1'b1;
    end else if (buf_v[ord2]) begin
      gnt_idx = ord2;
      gnt_any = 1'b1;
    end
    gnt = gnt_any ? (3'b001 << gnt_idx) : 3'b000;
  end

  // Ready depends only on state, grant, flush and reset.
  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      rdy[i] = !rst && !flush_i && (!buf_v[i] || gnt[i]);
      acc[i] = pkt_in[i][VBIT] && rdy[i];
    end
  end

  assign alu_ready_o = rdy[0];
  assign lsu_ready_o = rdy[1];
  assign bru_ready_o = rdy[2];

  // Holding buffers: flush clears, refill beats the grant clear.
  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      buf_d[i] = buf_q[i];
      if (flush_i) begin
        buf_d[i] = '0;
      end else if (acc[i]) begin
        buf_d[i] = pkt_in[i];
      end else if (gnt[i]) begin
        buf_d[i] = '0;
      end
    end
  end

  // Select the granted entry.
  always_comb begin
    gnt_pkt = '0;
    unique case (1'b1)
      gnt[0]:  gnt_pkt = buf_q[0];
      gnt[1]:  gnt_pkt = buf_q[1];
      gnt[2]:  gnt_pkt = buf_q[2];
      default: gnt_pkt = '0;
    endcase
  end

  // Next CDB register contents and round-robin pointer.
  always_comb begin
    cdb_d    = '0;
    grant_d  = '0;
    rr_ptr_d = rr_ptr_q;
    if (!flush_i && gnt_any) begin
      cdb_d       = gnt_pkt;
      cdb_d[VBIT] = 1'b1;
      grant_d     = gnt;
      rr_ptr_d    = nxt(gnt_idx);
    end
  end

  // Buffer, pointer and CDB output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NSRC; i++) begin
        buf_q[i] <= '0;
      end
      rr_ptr_q <= 2'd0;
      cdb_q    <= '0;
      grant_q  <= '0;
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        buf_q[i] <= buf_d[i];
      end
      rr_ptr_q <= rr_ptr_d;
      cdb_q    <= cdb_d;
      grant_q  <= grant_d;
    end
  end

  assign cdb_pkt_o = cdb_q;
  assign grant_o   = grant_q;

`ifdef WB_ARB_PERF_EN
  logic [31:0] perf_q [NSRC];
  logic [31:0] perf_d [NSRC];

  // Count cycles a buffered packet loses arbitration, saturating.
  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      perf_d[i] = perf_q[i];
      if (buf_v[i] && !gnt[i] && (perf_q[i] != 32'hFFFF_FFFF)) begin
        perf_d[i] = perf_q[i] + 32'd1;
      end
    end
  end

  // Conflict counters, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NSRC; i++) begin
        perf_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        perf_q[i] <= perf_d[i];
      end
    end
  end

  assign perf_conflict_o = {perf_q[2], perf_q[1], perf_q[0]};
`else
  assign perf_conflict_o = '0;
`endif

endmodule

// File: tb/tb_wb_cdb_arbiter.sv
// tb_wb_cdb_arbiter: vector table plus scoreboard bench for wb_cdb_arbiter.
// Perf expectations follow WB_ARB_PERF_EN.
module tb_wb_cdb_arbiter;

  localparam int WB_W = 45;
  typedef logic [WB_W-1:0] pkt_t;

  typedef struct {
    logic       fl;
    pkt_t       alu;
    pkt_t       lsu;
    pkt_t       bru;
    logic [2:0] rdy;
    pkt_t       cdb;
    logic [2:0] gnt;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        flush_i;
  pkt_t        alu_pkt_i, lsu_pkt_i, bru_pkt_i;
  logic        alu_ready_o, lsu_ready_o, bru_ready_o;
  pkt_t        cdb_pkt_o;
  logic [2:0]  grant_o;
  logic [95:0] perf_conflict_o;

  int total = 0;
  int bad   = 0;

  vec_t tbl[$];
  pkt_t alu_q[$];
  pkt_t bru_q[$];

  wb_cdb_arbiter dut (
    .clk             (clk),
    .rst             (rst),
    .flush_i         (flush_i),
    .alu_pkt_i       (alu_pkt_i),
    .alu_ready_o     (alu_ready_o),
    .lsu_pkt_i       (lsu_pkt_i),
    .lsu_ready_o     (lsu_ready_o),
    .bru_pkt_i       (bru_pkt_i),
    .bru_ready_o     (bru_ready_o),
    .cdb_pkt_o       (cdb_pkt_o),
    .grant_o         (grant_o),
    .perf_conflict_o (perf_conflict_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  function automatic pkt_t mk(input logic [4:0] tag, input logic [5:0] prd,
                              input logic [31:0] data, input logic rdu);
    return {1'b1, tag, prd, data, rdu};
  endfunction

  function automatic vec_t vv(input logic fl, input pkt_t a, input pkt_t l,
                              input pkt_t b, input logic [2:0] r,
                              input pkt_t c, input logic [2:0] g);
    vec_t v;
    v.fl = fl; v.alu = a; v.lsu = l; v.bru = b;
    v.rdy = r; v.cdb = c; v.gnt = g;
    return v;
  endfunction

  function automatic logic [2:0] rdys();
    return {bru_ready_o, lsu_ready_o, alu_ready_o};
  endfunction

  task automatic chk(input string nm, input logic [95:0] act,
                     input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic idle_in();
    flush_i   = 1'b0;
    alu_pkt_i = '0;
    lsu_pkt_i = '0;
    bru_pkt_i = '0;
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      flush_i   = tbl[i].fl;
      alu_pkt_i = tbl[i].alu;
      lsu_pkt_i = tbl[i].lsu;
      bru_pkt_i = tbl[i].bru;
      @(negedge clk);
      chk($sformatf("row%0d ready", i), 96'(rdys()), 96'(tbl[i].rdy));
      chk($sformatf("row%0d cdb", i), 96'(cdb_pkt_o), 96'(tbl[i].cdb));
      chk($sformatf("row%0d grant", i), 96'(grant_o), 96'(tbl[i].gnt));
      @(posedge clk);
      #1;
    end
    idle_in();
  endtask

  pkt_t p1, a1, l2, b3, l5, b6, a7, a8, b7, a9, l10, b11, bs;
  pkt_t z;

  initial begin
    z   = '0;
    p1  = mk(5'd3, 6'd10, 32'hDEAD_BEEF, 1'b1);
    a1  = mk(5'd1, 6'd1, 32'h0000_1111, 1'b1);
    l2  = mk(5'd2, 6'd2, 32'h0000_2222, 1'b1);
    b3  = mk(5'd3, 6'd3, 32'h0000_3333, 1'b1);
    l5  = mk(5'd5, 6'd5, 32'h0000_5555, 1'b1);
    b6  = mk(5'd6, 6'd6, 32'h0000_6666, 1'b1);
    a7  = mk(5'd9, 6'd7, 32'h0000_7777, 1'b1);
    a8  = mk(5'd8, 6'd8, 32'h0000_8888, 1'b1);
    b7  = mk(5'd7, 6'd12, 32'h0000_1234, 1'b0);
    a9  = mk(5'd9, 6'd9, 32'h0000_9999, 1'b1);
    l10 = mk(5'd10, 6'd10, 32'h0000_AAAA, 1'b1);
    b11 = mk(5'd11, 6'd11, 32'h0000_BBBB, 1'b1);
    bs  = mk(5'd20, 6'd30, 32'hB0B0_0000, 1'b1);

    // 0..3 single packet
    tbl.push_back(vv(0, p1, z, z, 3'b111, z, 3'b000));
    tbl.push_back(vv(0, z, z, z, 3'b111, z, 3'b000));
    tbl.push_back(vv(0, z, z, z, 3'b111, p1, 3'b001));
    tbl.push_back(vv(0, z, z, z, 3'b111, z, 3'b000));
    // 4..9 three-way collision
    tbl.push_back(vv(0, a1, l2, b3, 3'b111, z, 3'b000));
    tbl.push_back(vv(0, z, z, z, 3'b001, z, 3'b000));
    tbl.push_back(vv(0, z, z, z, 3'b011, a1, 3'b001));
    tbl.push_back(vv(0, z, z, z, 3'b111, l2, 3'b010));
    tbl.push_back(vv(0, z, z, z, 3'b111, b3, 3'b100));
    tbl.push_back(vv(0, z, z, z, 3'b111, z, 3'b000));
    // 10..17 flush, 18..21 rd_used=0
    tbl.push_back(vv(0, z, l5, b6, 3'b111, z, 3'b000));
    tbl.push_back(vv(1, a7, z, z, 3'b000, z, 3'b000));
    tbl.push_back(vv(0, z, z, z, 3'b111, z, 3'b000));
    tbl.push_back(vv(0, z, z, z, 3'b111, z, 3'b000));
    tbl.push_back(vv(0, a8, z, z, 3'b111, z, 3'b000));
    tbl.push_back(vv(0, z, z, z, 3'b111, z, 3'b000));
    tbl.push_back(vv(0, z, z, z, 3'b111, a8, 3'b001));
    tbl.push_back(vv(0, z, z, z, 3'b111, z, 3'b000));
    tbl.push_back(vv(0, z, z, b7, 3'b111, z, 3'b000));
    tbl.push_back(vv(0, z, z, z, 3'b111, z, 3'b000));
    tbl.push_back(vv(0, z, z, z, 3'b111, b7, 3'b100));
    tbl.push_back(vv(0, z, z, z, 3'b111, z, 3'b000));

    idle_in();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst cdb", 96'(cdb_pkt_o), 96'd0);
    chk("rst grant", 96'(grant_o), 96'd0);
    chk("rst ready", 96'(rdys()), 96'd0);
    chk("rst perf", perf_conflict_o, 96'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_rows(0, 3);

    do_reset();
    run_rows(4, 9);
    run_rows(4, 9);
`ifdef WB_ARB_PERF_EN
    chk("perf counters", perf_conflict_o, {32'd4, 32'd2, 32'd0});
`else
    chk("perf counters", perf_conflict_o, 96'd0);
`endif

    do_reset();
    run_rows(10, 21);

    // streaming ALU with a single BRU packet, scoreboard checked
    do_reset();
    begin
      int atag = 0;
      int seen_bru = -1;
      int popped = 0;
      logic bru_done = 1'b0;
      logic [2:0] hist [40];
      pkt_t exp_p;
      for (int cyc = 0; cyc < 35; cyc++) begin
        alu_pkt_i = (atag < 20) ?
          mk(atag[4:0], atag[5:0], 32'hA000_0000 + 32'(atag), 1'b1) : '0;
        bru_pkt_i = (cyc >= 5 && !bru_done) ? bs : '0;
        @(negedge clk);
        hist[cyc] = rdys();
        if (alu_pkt_i[WB_W-1] && alu_ready_o) begin
          alu_q.push_back(alu_pkt_i);
          atag++;
        end
        if (bru_pkt_i[WB_W-1] && bru_ready_o) begin
          bru_q.push_back(bru_pkt_i);
          bru_done = 1'b1;
        end
        if (cdb_pkt_o[WB_W-1]) begin
          if (grant_o == 3'b001 && alu_q.size() > 0) begin
            exp_p = alu_q.pop_front();
            popped++;
            chk($sformatf("stream alu c%0d", cyc), 96'(cdb_pkt_o), 96'(exp_p));
          end else if (grant_o == 3'b100 && bru_q.size() > 0) begin
            exp_p = bru_q.pop_front();
            seen_bru = cyc;
            chk($sformatf("stream bru c%0d", cyc), 96'(cdb_pkt_o), 96'(exp_p));
          end else begin
            chk($sformatf("stream stray c%0d", cyc), 96'(grant_o), 96'd0);
          end
        end
        @(posedge clk);
        #1;
      end
      idle_in();
      chk("stream alu accepted", 96'(atag), 96'd20);
      chk("stream alu broadcast", 96'(popped), 96'd20);
      chk("stream alu left", 96'(alu_q.size()), 96'd0);
      chk("stream bru left", 96'(bru_q.size()), 96'd0);
      chk("stream bru by c8", 96'(seen_bru >= 6 && seen_bru <= 8), 96'd1);
      if (seen_bru >= 1) begin
        chk("stream alu stalled", 96'(hist[seen_bru-1][0]), 96'd0);
      end
    end

    // async reset while buffers hold LSU and BRU packets
    do_reset();
    alu_pkt_i = a9;
    lsu_pkt_i = l10;
    bru_pkt_i = b11;
    @(posedge clk);
    #1;
    idle_in();
    @(posedge clk);
    #3;
    chk("pre-rst cdb", 96'(cdb_pkt_o), 96'(a9));
    rst = 1'b1;
    #1;
    chk("async rst cdb", 96'(cdb_pkt_o), 96'd0);
    chk("async rst grant", 96'(grant_o), 96'd0);
    chk("async rst ready", 96'(rdys()), 96'd0);
    #2;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("post-rst valid c%0d", i), 96'(cdb_pkt_o[WB_W-1]), 96'd0);
      chk($sformatf("post-rst grant c%0d", i), 96'(grant_o), 96'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_cdb_arbiter.md
Name: wb_cdb_arbiter

Overview:
- Shares the single common data bus (CDB) among the three functional-unit completion buses: ALU, LSU and BRU.
- Each source has a one-entry holding buffer with a valid/ready handshake.
- A round-robin arbiter grants one buffered packet per cycle into a registered CDB output.
- The CDB output feeds ROB completion, RS wakeup and PRF write; it sits between the FU outputs and those consumers.

Parameters:
- XLEN, 32, data width.
- ROB_W, 5, ROB tag width.
- PREG_W, 6, physical register index width.
- WB_W, 1+ROB_W+PREG_W+XLEN+1, packet width. Packed field order, MSB to LSB: valid, rob_tag, prd, data, rd_used.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush_i  input  1  pipeline flush: discards all buffered/in-flight packets.
- alu_pkt_i  input  WB_W  ALU completion packet.
- alu_ready_o  output  1  ALU buffer can accept.
- lsu_pkt_i  input  WB_W  LSU completion packet.
- lsu_ready_o  output  1  LSU buffer can accept.
- bru_pkt_i  input  WB_W  BRU completion packet.
- bru_ready_o  output  1  BRU buffer can accept.
- cdb_pkt_o  output  WB_W  registered CDB broadcast packet.
- grant_o  output  3  registered one-hot source of cdb_pkt_o: bit0 ALU, bit1 LSU, bit2 BRU. Zero when idle.
- perf_conflict_o  output  3x32 (96)  per-source conflict counters; see Optional Feature.

Behaviour:
- Reset (async, active-high): all buffers empty, cdb_pkt_o = 0, grant_o = 0, rr_ptr = 0 (ALU highest priority), perf counters 0. Ready outputs are 0 while rst is high.
- src_ready_o = !rst && !flush_i && (buffer empty || buffer granted this cycle). Ready is combinational from state and the current grant, not from pkt_i.
- Accept: when pkt_i.valid && ready, the packet is written into the buffer at the clock edge. If pkt_i.valid && !ready, the source must hold the packet stable; nothing is captured.
- Arbitration is combinational over buffer-valid bits:
  - Priority order starts at rr_ptr: rr_ptr, rr_ptr+1, rr_ptr+2, mod 3.
  - At most one grant per cycle.
  - Granted buffer is cleared at the edge unless refilled in the same cycle; refill has priority over clear.
  - rr_ptr <= (granted index + 1) mod 3. rr_ptr is unchanged when there is no grant.
- Output register: cdb_pkt_o <= granted buffer contents with valid=1, and grant_o <= one-hot grant. With no grant, cdb_pkt_o.valid <= 0 and grant_o <= 0; other fields are don't-care (drive 0).
- CDB valid is a single-cycle pulse per packet. There is no downstream backpressure.
- Latency: packet accepted at edge E appears on cdb_pkt_o after edge E+1 if uncontended (2-cycle pin-to-pin). Throughput: 1 packet/cycle.
- Fairness: a buffered packet is granted within 3 cycles of entering the buffer.
- Packets with rd_used=0 (stores, branches) are broadcast like any other packet; the arbiter never inspects rd_used or prd.
- flush_i high at an edge:
  - All buffers cleared; inputs in that cycle dropped (ready=0).
  - cdb_pkt_o.valid <= 0, grant_o <= 0.
  - rr_ptr preserved.
  - Flush wins over simultaneous accept and grant.
- rst asserted mid-operation: immediate clear of all state, regardless of clock.

Optional Feature:
- Macro: WB_ARB_PERF_EN.
- Defined: three 32-bit saturating counters, packed on perf_conflict_o as [31:0] ALU, [63:32] LSU, [95:64] BRU.
  - A counter increments each cycle its buffer is valid but not granted (arbitration loss), including flush cycles.
  - Counters saturate at 0xFFFFFFFF. They are cleared only by rst.
- Undefined: no counter flops; perf_conflict_o tied to 0. Port list unchanged.

Test Plan:
- Single packet: after reset, alu_pkt_i {valid=1, rob_tag=3, prd=10, data=0xDEADBEEF, rd_used=1} for one cycle at cycle 0 -> alu_ready_o=1 at cycle 0; cdb_pkt_o carries identical fields with valid=1 and grant_o=001 for exactly cycle 2 only.
- Three-way collision: all three sources valid in cycle 0 after reset (rob_tags 1/2/3) -> all accepted in cycle 0; CDB shows ALU, LSU, BRU in cycles 2, 3, 4; grant_o = 001, 010, 100; no gaps.
- Fairness under streaming: ALU valid every cycle (rob_tag increments), BRU single packet at cycle 5 -> BRU appears on CDB by cycle 8 at the latest; alu_ready_o low in any cycle ALU's full buffer loses arbitration; no ALU packet lost or duplicated (tag sequence checked).
- Flush: LSU and BRU buffered, flush_i pulsed one cycle while alu_pkt_i valid -> no cdb_pkt_o.valid for the following cycles; all ready outputs 1 the cycle after flush; ALU packet from the flush cycle never appears; the next new packet broadcasts normally with 2-cycle latency.
- rd_used=0 and reset mid-flight: a BRU packet {rob_tag=7, rd_used=0} is broadcast with rd_used=0 unchanged; rst asserted asynchronously while two buffers are full -> cdb_pkt_o, grant_o and ready outputs drop to 0 immediately, and neither packet appears after rst deasserts.
- WB_ARB_PERF_EN: three-way collision repeated twice -> perf_conflict_o ALU=0, LSU=2, BRU=4. With the macro undefined, perf_conflict_o reads 0.
